// File: rtl/gate_tt_checker.sv
// Self-running truth-table checker: sweeps every input vector onto a small
// combinational gate, samples its output after a settle delay and scores it.
module gate_tt_checker #(
  parameter int                       N_IN   = 2,
  parameter logic [(1 << N_IN)-1:0]   TRUTH  = 4'b0111,
  parameter int                       SETTLE = 1,
  parameter int                       ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  x,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [N_IN-1:0]  first_err,
  output logic             first_vld
);

  localparam int              NV       = 1 << N_IN;
  localparam logic [N_IN:0]   VLAST    = (N_IN+1)'(NV - 1);
  localparam int              CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [N_IN:0]    vec_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic [N_IN-1:0]  ferr_q;
  logic             fvld_q;

  logic             mism;
  logic [ERR_W-1:0] err_d;

  // Mismatch of the held vector and the error count it would produce, saturating.
  always_comb begin
    mism  = (y != TRUTH[vec_q[N_IN-1:0]]);
    err_d = err_q;
    if (mism && !(&err_q)) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ferr_q  <= '0;
      fvld_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            vec_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ferr_q  <= '0;
            fvld_q  <= 1'b0;
          end
        end
        RUN: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            err_q <= err_d;
            if (mism && !fvld_q) begin
              ferr_q <= vec_q[N_IN-1:0];
              fvld_q <= 1'b1;
            end
            if (vec_q == VLAST) begin
              // pass uses err_d so a mismatch on the final vector is counted.
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              vec_q <= vec_q + (N_IN+1)'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign x         = vec_q[N_IN-1:0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign first_err = ferr_q;
  assign first_vld = fvld_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Directed bench for gate_tt_checker: three instances (default, SETTLE=3, ERR_W=1)
// each fed by a behavioural gate model selected per step.
module tb_gate_tt_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // 0 = NAND2, 1 = AND2, 2 = stuck at 1
  function automatic logic model(input int m, input logic [1:0] xv);
    case (m)
      0:       return ~(xv[0] & xv[1]);
      1:       return xv[0] & xv[1];
      default: return 1'b1;
    endcase
  endfunction

  logic       start0, y0, busy0, done0, pass0, fv0;
  logic [1:0] x0, fe0;
  logic [7:0] err0;
  int         mode0;

  logic       start1, y1, busy1, done1, pass1, fv1;
  logic [1:0] x1, fe1;
  logic [7:0] err1;

  logic       start2, y2, busy2, done2, pass2, fv2;
  logic [1:0] x2, fe2;
  logic [0:0] err2;

  always_comb y0 = model(mode0, x0);
  always_comb y1 = model(0, x1);
  always_comb y2 = model(1, x2);

  gate_tt_checker u0 (
    .clk(clk), .rst(rst), .start(start0), .x(x0), .y(y0), .busy(busy0),
    .done(done0), .pass(pass0), .err_cnt(err0), .first_err(fe0), .first_vld(fv0)
  );

  gate_tt_checker #(.SETTLE(3)) u1 (
    .clk(clk), .rst(rst), .start(start1), .x(x1), .y(y1), .busy(busy1),
    .done(done1), .pass(pass1), .err_cnt(err1), .first_err(fe1), .first_vld(fv1)
  );

  gate_tt_checker #(.ERR_W(1)) u2 (
    .clk(clk), .rst(rst), .start(start2), .x(x2), .y(y2), .busy(busy2),
    .done(done2), .pass(pass2), .err_cnt(err2), .first_err(fe2), .first_vld(fv2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Full sweep on u0 with the NAND2 expectation; call at post-edge phase.
  task automatic sweep0(input int ee, input int efe, input int efv, input int ep);
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    chk("u0_busy_on", int'(busy0), 1);
    chk("u0_x_first", int'(x0), 0);
    chk("u0_err_clr", int'(err0), 0);
    for (int v = 1; v < 4; v++) begin
      @(posedge clk); #1;
      chk("u0_x_seq", int'(x0), v);
      chk("u0_done_early", int'(done0), 0);
    end
    @(posedge clk); #1;
    chk("u0_done", int'(done0), 1);
    chk("u0_busy_off", int'(busy0), 0);
    chk("u0_pass", int'(pass0), ep);
    chk("u0_err_cnt", int'(err0), ee);
    chk("u0_first_vld", int'(fv0), efv);
    chk("u0_first_err", int'(fe0), efe);
    chk("u0_x_hold_last", int'(x0), 3);
    @(posedge clk); #1;
    chk("u0_done_pulse", int'(done0), 0);
  endtask

  initial begin
    int dcount;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; mode0 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x", int'(x0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_pass", int'(pass0), 0);
    chk("rst_err", int'(err0), 0);
    chk("rst_fvld", int'(fv0), 0);
    chk("rst_ferr", int'(fe0), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    mode0 = 0; sweep0(0, 0, 0, 1);
    mode0 = 1; sweep0(4, 0, 1, 0);
    mode0 = 2; sweep0(1, 3, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold_err", int'(err0), 1);
    chk("idle_hold_ferr", int'(fe0), 3);
    chk("idle_hold_pass", int'(pass0), 0);
    chk("idle_hold_x", int'(x0), 3);

    // Reset while x=2 aborts with no done pulse.
    mode0 = 0;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_x_before", int'(x0), 2);
    #2 rst = 1'b1;
    #1;
    chk("abort_x", int'(x0), 0);
    chk("abort_busy", int'(busy0), 0);
    chk("abort_err", int'(err0), 0);
    @(posedge clk); #1;
    chk("abort_no_done", int'(done0), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_still_idle", int'(busy0), 0);
    sweep0(0, 0, 0, 1);

    // SETTLE=3: each vector held three cycles, done 12 edges after start.
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("s3_x_0", int'(x1), 0);
    for (int i = 1; i < 12; i++) begin
      @(posedge clk); #1;
      chk("s3_x_hold", int'(x1), i / 3);
      chk("s3_busy", int'(busy1), 1);
    end
    @(posedge clk); #1;
    chk("s3_done", int'(done1), 1);
    chk("s3_pass", int'(pass1), 1);
    chk("s3_err", int'(err1), 0);
    @(posedge clk); #1;
    chk("s3_done_pulse", int'(done1), 0);

    // ERR_W=1 with AND2 and start held high throughout.
    start2 = 1'b1;
    @(posedge clk); #1;
    chk("e1_busy", int'(busy2), 1);
    chk("e1_x0", int'(x2), 0);
    dcount = 0;
    for (int i = 1; i <= 18; i++) begin
      @(posedge clk); #1;
      if (done2) dcount++;
      if (i == 2) chk("e1_sat_mid", int'(err2), 1);
      if (i == 4) begin
        chk("e1_done", int'(done2), 1);
        chk("e1_sat_end", int'(err2), 1);
        chk("e1_pass", int'(pass2), 0);
        chk("e1_ferr", int'(fe2), 0);
        chk("e1_fvld", int'(fv2), 1);
      end
      if (i == 5) begin
        chk("e1_no_restart_done", int'(busy2), 0);
        chk("e1_done_one", int'(done2), 0);
      end
      if (i == 6) begin
        chk("e1_restart", int'(busy2), 1);
        chk("e1_restart_err", int'(err2), 0);
      end
    end
    chk("e1_done_count", dcount, 3);
    start2 = 1'b0;
    repeat (8) @(posedge clk);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
